// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: a prescaler paces a digit index, and the
// segment/anode outputs are registered from the index and the captured shadow value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic [4*N_DIGITS-1:0] val_sh;
  logic [N_DIGITS-1:0]   dp_sh;

  logic [N_DIGITS-1:0]   blank_mask;
  logic                  zero_above;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_next;
  logic [6:0]            dec_seg;

  assign tick = (presc == PRE_LAST);

  // Prescaler and index free-run independent of en and load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_sh <= '0;
      dp_sh  <= '0;
    end else if (load) begin
      val_sh <= value;
      dp_sh  <= dp_in;
    end
  end

  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (val_sh[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_lz & zero_above & (i != 0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib    = val_sh[4*i +: 4];
        cur_dp     = dp_sh[i];
        cur_blank  = blank_mask[i];
        an_next[i] = 1'b0;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else if (!en) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= cur_blank ? SEG_BLANK : dec_seg;
      dp  <= ~cur_dp;
      an  <= an_next;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 value  input  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
REQ-006 dp_in  input  N_DIGITS  decimal-point request per digit, 1 = lit.
REQ-007 load  input  1  capture strobe for value/dp_in.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 en  input  1  display enable; 0 = all digits dark.
REQ-010 seg  output  7  segments g..a (seg[6]=g, seg[0]=a), active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 an  output  N_DIGITS  digit anodes, active-low, at most one low.

Function
REQ-013 When load=1 at a clock edge, value and dp_in SHALL be captured into shadow registers; the display SHALL use only the shadow registers.
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on the cycle it holds REFRESH_DIV-1 it SHALL assert an internal tick.
REQ-015 On tick, digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-016 Prescaler and index SHALL run regardless of en and load.
REQ-017 seg, dp and an SHALL be registered, recomputed every cycle from the current index and shadow registers (one-cycle output latency).
REQ-018 load at edge t SHALL update the shadow at t; outputs SHALL reflect it from edge t+1 for the currently scanned digit.
REQ-019 load coincident with tick: both SHALL take effect at the same edge, with no lost update.
REQ-020 Hex decode (seg, hex) SHALL be: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E.
REQ-021 With blank_lz=1, digit i>0 SHALL show seg=7F when its nibble and all higher nibbles are 0; digit 0 is never blanked.
REQ-022 A blanked digit SHALL still drive its anode and dp per dp_in.
REQ-023 When en=1, an SHALL have only the bit at the current index low; dp SHALL be ~dp_shadow[index].
REQ-024 When en=0, an SHALL be all ones, seg=7F and dp=1 from the next edge.

Reset
REQ-025 While rst_n=0: prescaler=0, index=0, value and dp shadows=0, seg=7F, dp=1, an all ones.
REQ-026 Reset asserted mid-scan SHALL clear all state immediately, without waiting for clk.
REQ-027 After rst_n deassert with en=1, digit 0 SHALL be driven from the first edge, showing "0" (seg=40).

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry segment table constant and SEG_BLANK=7'h7F.
REQ-029 Decode SHALL be a combinational sub-module seg7_hex_decoder (4-bit in, 7-bit active-low out) using seg7_pkg.
REQ-030 Index width SHALL be max(1, clog2(N_DIGITS)); prescaler width SHALL be clog2(REFRESH_DIV).

Verification (N_DIGITS=4, REFRESH_DIV=4)
REQ-031 Reset, en=1, no load -> an cycles 1110,1101,1011,0111 every 4 clk; seg=40 on every digit.
REQ-032 load value=16'h1A3F, dp_in=0100 -> digit0 seg=0E, digit1 seg=30, digit2 seg=08 with dp=0, digit3 seg=79.
REQ-033 blank_lz=1, load 16'h0007 -> digits 3..1 seg=7F, digit0 seg=78; load 16'h0000 -> digit0 seg=40, others 7F.
REQ-034 en=0 mid-scan -> an=1111, seg=7F one cycle later; en=1 -> scan resumes at the index reached meanwhile.
REQ-035 load held on the tick edge with 16'hFFFF -> next digit shows seg=0E from the following cycle.
REQ-036 rst_n low for 3 ns between edges -> outputs reset without a clk edge; index restarts at digit 0.
